// File: rtl/burst_pi_pkg.sv
// burst_pi_pkg
// Shared types and helpers for the chroma-burst PI loop filter.
//   state_t     - sequencing states of the burst filter FSM
//   sat_signed  - clamps a signed 64-bit value into the range of a signed
//                 field of the given width
//   abs_signed  - magnitude of a signed 64-bit value
package burst_pi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CAPTURE = 2'd2,
    APPLY   = 2'd3
  } state_t;

  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] value,
    input int unsigned        width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] result;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      result = hi;
    end else if (value < lo) begin
      result = lo;
    end else begin
      result = value;
    end
    return result;
  endfunction

  function automatic logic [63:0] abs_signed(input logic signed [63:0] value);
    logic [63:0] result;
    if (value < 64'sd0) begin
      result = 64'(-value);
    end else begin
      result = 64'(value);
    end
    return result;
  endfunction

endpackage

// File: rtl/burst_lock_monitor.sv
// burst_lock_monitor
// Tracks loop health from the stream of accepted burst updates and the
// line strobe.  Counts consecutive good updates to declare lock, and counts
// consecutive lines without an accepted update to declare holdover.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   enable       - 0 freezes every counter and flag; strobes are ignored
//   line_strobe  - one pulse per video line
//   accept       - one pulse per accepted burst update
//   good         - accepted burst error magnitude is below the lock threshold
//   locked       - loop lock indicator
//   holdover     - bursts missing for too many lines
module burst_lock_monitor #(
  parameter int LOCK_LINES = 8,
  parameter int MISS_LINES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic line_strobe,
  input  logic accept,
  input  logic good,
  output logic locked,
  output logic holdover
);

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int MW = $clog2(MISS_LINES + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LINES);

  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic          seen;
  logic [GW-1:0] good_next;
  logic [MW-1:0] miss_next;

  always_comb begin
    good_next = good_cnt;
    if (good_cnt != GOOD_MAX) begin
      good_next = good_cnt + 1'b1;
    end
    miss_next = '0;
    if (!seen) begin
      miss_next = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      miss_cnt <= '0;
      seen     <= 1'b0;
      locked   <= 1'b0;
      holdover <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        // An update landing on the strobe cycle belongs to the line that the
        // strobe closes, so the next line starts unseen.
        miss_cnt <= '0;
        holdover <= 1'b0;
        seen     <= !line_strobe;
        if (good) begin
          good_cnt <= good_next;
          locked   <= (good_next == GOOD_MAX);
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end else if (line_strobe) begin
        seen     <= 1'b0;
        miss_cnt <= miss_next;
        if (miss_next == MISS_MAX) begin
          holdover <= 1'b1;
          locked   <= 1'b0;
          good_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/burst_pi_filter.sv
// burst_pi_filter
// PI loop filter for the chroma-burst PLL.  Sums the demodulated burst error
// over each burst gate, rejects short bursts, and once per accepted burst
// applies a saturating proportional + clamped integral update to the NCO
// frequency offset.  Lock and holdover status come from burst_lock_monitor.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   enable        - 0 freezes the loop and aborts any accumulation
//   integ_clr     - clears integrator and offset_out (wins over updates)
//   line_strobe   - one pulse per video line
//   burst_active  - burst gate
//   error_in      - signed burst error sample
//   offset_out    - signed frequency offset to the NCO
//   update_valid  - pulses for one cycle when offset_out takes a new update
//   captured_err  - last accepted burst sum
//   locked        - loop lock indicator
//   holdover      - bursts missing; output frozen
//
// state   | meaning
// IDLE    | waiting for the burst gate to open
// ACCUM   | summing error samples while the gate is open
// CAPTURE | length check; latch burst sum and step the integrator
// APPLY   | compute and publish the new offset
module burst_pi_filter
  import burst_pi_pkg::*;
#(
  parameter int     ERR_W       = 12,
  parameter int     ACC_W       = 24,
  parameter int     CNT_W       = 7,
  parameter int     OUT_W       = 32,
  parameter int     KP_SHIFT    = 6,
  parameter int     KI_SHIFT    = 10,
  parameter longint INT_LIM     = 2**27,
  parameter int     MIN_SAMPLES = 16,
  parameter int     LOCK_THRESH = 64,
  parameter int     LOCK_LINES  = 8,
  parameter int     MISS_LINES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             integ_clr,
  input  logic             line_strobe,
  input  logic             burst_active,
  input  logic [ERR_W-1:0] error_in,
  output logic [OUT_W-1:0] offset_out,
  output logic             update_valid,
  output logic [ACC_W-1:0] captured_err,
  output logic             locked,
  output logic             holdover
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  MIN_CNT    = CNT_W'(MIN_SAMPLES);
  localparam logic [63:0]       LOCK_TH64  = 64'(LOCK_THRESH);
  localparam logic signed [63:0] INT_HI    = INT_LIM;
  localparam logic signed [63:0] INT_LO    = -INT_LIM;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] integ;

  logic signed [63:0] err_ext;
  logic signed [63:0] acc_ext;
  logic signed [63:0] cap_ext;
  logic signed [63:0] integ_ext;
  logic signed [63:0] acc_sum;
  logic signed [63:0] integ_raw;
  logic signed [63:0] integ_clamped;
  logic signed [63:0] off_sat;
  logic               accept;
  logic               good;

  always_comb begin
    err_ext   = {{(64-ERR_W){error_in[ERR_W-1]}}, error_in};
    acc_ext   = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    cap_ext   = {{(64-ACC_W){captured_err[ACC_W-1]}}, captured_err};
    integ_ext = {{(64-OUT_W){integ[OUT_W-1]}}, integ};

    acc_sum = sat_signed(acc_ext + err_ext, ACC_W);

    // Symmetric clamp keeps the integrator from winding up while the loop
    // is pinned against the NCO range.
    integ_raw = integ_ext + acc_ext;
    if (integ_raw > INT_HI) begin
      integ_clamped = INT_HI;
    end else if (integ_raw < INT_LO) begin
      integ_clamped = INT_LO;
    end else begin
      integ_clamped = integ_raw;
    end

    // In APPLY, integ already holds the value stepped in CAPTURE.
    off_sat = sat_signed((cap_ext >>> KP_SHIFT) + (integ_ext >>> KI_SHIFT), OUT_W);

    accept = enable && (state == CAPTURE) && (cnt >= MIN_CNT);
    good   = abs_signed(acc_ext) < LOCK_TH64;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      integ        <= '0;
      offset_out   <= '0;
      captured_err <= '0;
      update_valid <= 1'b0;
    end else begin
      update_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (burst_active) begin
              acc   <= err_ext[ACC_W-1:0];
              cnt   <= CNT_W'(1);
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (burst_active) begin
              // Once the sample counter is full the rest of the burst is
              // dropped so sum and count stay consistent.
              if (cnt != CNT_MAX) begin
                acc <= acc_sum[ACC_W-1:0];
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (accept) begin
              captured_err <= acc;
              integ        <= integ_clamped[OUT_W-1:0];
              state        <= APPLY;
            end else begin
              state <= IDLE;
            end
            acc <= '0;
            cnt <= '0;
          end
          APPLY: begin
            offset_out   <= off_sat[OUT_W-1:0];
            update_valid <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (integ_clr) begin
        integ      <= '0;
        offset_out <= '0;
      end
    end
  end

  burst_lock_monitor #(
    .LOCK_LINES(LOCK_LINES),
    .MISS_LINES(MISS_LINES)
  ) u_lock_monitor (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .line_strobe(line_strobe),
    .accept     (accept),
    .good       (good),
    .locked     (locked),
    .holdover   (holdover)
  );

endmodule

// File: tb/tb_burst_pi_filter.sv
// tb_burst_pi_filter
// Randomized and directed stimulus for burst_pi_filter, checked against a
// transaction-level model of the loop (burst sum -> PI update -> lock state).
// The integrator limit is lowered so that the clamp is reached in a few
// dozen lines.
module tb_burst_pi_filter;

  localparam int     ERR_W   = 12;
  localparam int     ACC_W   = 24;
  localparam int     CNT_W   = 7;
  localparam int     OUT_W   = 32;
  localparam int     KP      = 6;
  localparam int     KI      = 10;
  localparam longint INT_LIM = 2**22;
  localparam int     MIN_S   = 16;
  localparam int     LOCK_TH = 64;
  localparam int     LOCK_L  = 8;
  localparam int     MISS_L  = 4;
  localparam int     CNT_MAX = 2**CNT_W - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             integ_clr;
  logic             line_strobe;
  logic             burst_active;
  logic [ERR_W-1:0] error_in;
  logic [OUT_W-1:0] offset_out;
  logic             update_valid;
  logic [ACC_W-1:0] captured_err;
  logic             locked;
  logic             holdover;

  always #5 clk = ~clk;

  burst_pi_filter #(
    .ERR_W(ERR_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .OUT_W(OUT_W),
    .KP_SHIFT(KP), .KI_SHIFT(KI), .INT_LIM(INT_LIM), .MIN_SAMPLES(MIN_S),
    .LOCK_THRESH(LOCK_TH), .LOCK_LINES(LOCK_L), .MISS_LINES(MISS_L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .integ_clr   (integ_clr),
    .line_strobe (line_strobe),
    .burst_active(burst_active),
    .error_in    (error_in),
    .offset_out  (offset_out),
    .update_valid(update_valid),
    .captured_err(captured_err),
    .locked      (locked),
    .holdover    (holdover)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  longint m_integ, m_off, m_cap;
  int     m_good, m_miss;
  bit     m_seen, m_locked, m_hold;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat_n(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint s_out();
    return longint'($signed(offset_out));
  endfunction

  function automatic longint s_cap();
    return longint'($signed(captured_err));
  endfunction

  task automatic model_reset();
    m_integ = 0; m_off = 0; m_cap = 0;
    m_good = 0; m_miss = 0; m_seen = 0; m_locked = 0; m_hold = 0;
  endtask

  task automatic model_strobe();
    m_miss = m_seen ? 0 : ((m_miss < MISS_L) ? m_miss + 1 : m_miss);
    m_seen = 0;
    if (m_miss == MISS_L) begin
      m_hold = 1; m_locked = 0; m_good = 0;
    end
  endtask

  task automatic model_accept(input longint sum, input bit strobe_same);
    longint ig;
    m_cap = sum;
    ig = m_integ + sum;
    m_integ = (ig > INT_LIM) ? INT_LIM : ((ig < -INT_LIM) ? -INT_LIM : ig);
    m_off = sat_n((m_cap >>> KP) + (m_integ >>> KI), OUT_W);
    if (((sum < 0) ? -sum : sum) < LOCK_TH) begin
      if (m_good < LOCK_L) m_good++;
      m_locked = (m_good == LOCK_L);
    end else begin
      m_good = 0; m_locked = 0;
    end
    m_hold = 0; m_miss = 0;
    m_seen = !strobe_same;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_off"}, s_out(), m_off);
    check({tag, "_cap"}, s_cap(), m_cap);
    check({tag, "_lock"}, longint'(locked), longint'(m_locked));
    check({tag, "_hold"}, longint'(holdover), longint'(m_hold));
  endtask

  // mode 0: constant val, 1: full-range random, 2: small random
  task automatic do_burst(input string tag, input int n, input int mode, input int val,
                          input bit strobe_cap, input bit clr_apply);
    longint sum;
    int     cnt;
    int     e;
    bit     acc_ok;
    sum = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       e = val;
        1:       e = int'($urandom_range(4095)) - 2048;
        default: e = int'($urandom_range(6)) - 3;
      endcase
      burst_active = 1'b1;
      error_in     = ERR_W'(e);
      if (cnt < CNT_MAX) begin
        sum = sat_n(sum + e, ACC_W);
        cnt++;
      end
      tick();
    end
    burst_active = 1'b0;
    error_in     = '0;
    tick();
    line_strobe = strobe_cap;
    tick();
    check({tag, "_uv_early"}, longint'(update_valid), 0);
    line_strobe = 1'b0;
    integ_clr   = clr_apply;
    tick();
    integ_clr = 1'b0;
    acc_ok = (cnt >= MIN_S);
    if (acc_ok) model_accept(sum, strobe_cap);
    else if (strobe_cap) model_strobe();
    if (clr_apply) begin
      m_integ = 0; m_off = 0;
    end
    check({tag, "_uv"}, longint'(update_valid), longint'(acc_ok));
    check_state(tag);
    tick();
    check({tag, "_uv_late"}, longint'(update_valid), 0);
  endtask

  task automatic do_strobe(input string tag);
    line_strobe = 1'b1;
    tick();
    line_strobe = 1'b0;
    model_strobe();
    check({tag, "_lock"}, longint'(locked), longint'(m_locked));
    check({tag, "_hold"}, longint'(holdover), longint'(m_hold));
  endtask

  longint saved_off;
  int     r;

  initial begin
    rst = 1'b1; enable = 1'b1; integ_clr = 1'b0; line_strobe = 1'b0;
    burst_active = 1'b0; error_in = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_uv", longint'(update_valid), 0);
    check_state("rst");

    // single long burst: 40 x +100
    do_burst("b40", 40, 0, 100, 1'b0, 1'b0);
    check("b40_cap_lit", s_cap(), 4000);
    check("b40_off_lit", s_out(), 65);
    do_strobe("s1");

    // short burst is rejected and counts as a miss
    saved_off = s_out();
    do_burst("short", 10, 0, 100, 1'b0, 1'b0);
    check("short_off_hold", s_out(), saved_off);
    do_strobe("s2");

    // lock acquisition and loss
    for (int i = 0; i < LOCK_L; i++) begin
      do_burst("lockb", 40, 0, 1, 1'b0, 1'b0);
      do_strobe("locks");
    end
    check("lock8", longint'(locked), 1);
    do_burst("unlock", 40, 0, 10, 1'b0, 1'b0);
    check("unlock_lit", longint'(locked), 0);
    do_strobe("s3");

    // re-lock, then lose bursts into holdover
    for (int i = 0; i < LOCK_L; i++) begin
      do_burst("relock", 40, 0, 1, 1'b0, 1'b0);
      do_strobe("relocks");
    end
    check("relock8", longint'(locked), 1);
    saved_off = s_out();
    for (int i = 0; i < MISS_L; i++) do_strobe("miss");
    check("hold_lit", longint'(holdover), 1);
    check("hold_unlock", longint'(locked), 0);
    check("hold_off", s_out(), saved_off);
    do_burst("exit", 40, 0, -5, 1'b0, 1'b0);
    check("exit_hold", longint'(holdover), 0);

    // enable=0 aborts accumulation and ignores line_strobe
    for (int i = 0; i < 10 && m_miss < MISS_L - 1; i++) do_strobe("pre_en");
    saved_off = s_out();
    burst_active = 1'b1;
    error_in     = ERR_W'(300);
    repeat (20) tick();
    enable = 1'b0;
    tick();
    line_strobe = 1'b1;
    tick();
    line_strobe = 1'b0;
    tick();
    enable = 1'b1;
    burst_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_uv", longint'(update_valid), 0);
    end
    check("en_off", s_out(), saved_off);
    check("en_hold", longint'(holdover), longint'(m_hold));
    do_strobe("post_en");

    // randomized mix of bursts and strobes
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(9));
      if (r < 2) begin
        do_strobe("rnd_s");
      end else if (r == 2) begin
        do_burst("rnd_short", int'($urandom_range(1, MIN_S - 1)), 1, 0,
                 1'($urandom_range(1)), 1'b0);
      end else if (r == 9) begin
        do_burst("rnd_long", int'($urandom_range(120, 135)), 1, 0,
                 1'($urandom_range(1)), 1'b0);
      end else begin
        do_burst("rnd", int'($urandom_range(MIN_S, 60)), (r < 6) ? 2 : 1, 0,
                 ($urandom_range(3) == 0), 1'b0);
      end
    end

    // saturation: full-scale error over full-length bursts
    do_burst("sat0", 130, 0, 2047, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      do_burst("sat", 130, 0, 2047, 1'b0, 1'b0);
      check("sat_pos", longint'(offset_out[OUT_W-1]), 0);
    end
    check("sat_cap_lit", s_cap(), 127 * 2047);
    check("sat_off_lit", s_out(), ((127 * 2047) >>> KP) + (INT_LIM >>> KI));

    // integrator clear on the APPLY cycle
    do_burst("clr", 40, 0, 100, 1'b0, 1'b1);
    check("clr_off_lit", s_out(), 0);
    do_burst("clr_next", 40, 0, 100, 1'b0, 1'b0);
    check("clr_next_lit", s_out(), 65);

    // reset in the middle of a burst
    burst_active = 1'b1;
    error_in     = ERR_W'(100);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    model_reset();
    check("mrst_uv", longint'(update_valid), 0);
    check_state("mrst");
    rst = 1'b0;
    burst_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mrst_uv_after", longint'(update_valid), 0);
    end
    check_state("mrst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_pi_filter.md
Name: burst_pi_filter

Overview:
- Parametrised PI loop filter for the chroma-burst PLL. Sits between the burst demodulator (error_in is the red/quadrature component) and the NCO frequency-offset input.
- Accumulates error over each burst and rejects short bursts.
- Applies a saturating PI update once per line with anti-windup.
- Reports lock and enters holdover (frozen output) when bursts go missing.

Parameters:
- ERR_W, 12, error_in width (signed)
- ACC_W, 24, burst accumulator width (signed, saturating)
- CNT_W, 7, sample counter width (saturates at 2^CNT_W-1)
- OUT_W, 32, integrator and offset_out width (signed)
- KP_SHIFT, 6, proportional gain = 2^-KP_SHIFT
- KI_SHIFT, 10, integral gain = 2^-KI_SHIFT
- INT_LIM, 2**27, integrator clamp magnitude (anti-windup)
- MIN_SAMPLES, 16, minimum burst length for a valid update
- LOCK_THRESH, 64, abs(captured error) below this counts as "good"
- LOCK_LINES, 8, consecutive good updates needed to assert locked
- MISS_LINES, 4, consecutive line_strobes without a valid update before holdover

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- enable, in, 1, 0 = freeze loop and abort any accumulation
- integ_clr, in, 1, synchronous clear of integrator and offset_out
- line_strobe, in, 1, one-cycle pulse per video line
- burst_active, in, 1, high during the burst gate
- error_in, in, ERR_W, signed demodulated burst error
- offset_out, out, OUT_W, signed frequency offset to NCO
- update_valid, out, 1, one-cycle pulse when offset_out changes from a loop update
- captured_err, out, ACC_W, last accepted burst sum
- locked, out, 1, loop lock indicator
- holdover, out, 1, bursts missing; output frozen

Behaviour:
- Reset (rst=1 on a clk edge): all outputs 0, FSM = IDLE, all counters and accumulator 0.
- FSM states are IDLE, ACCUM, CAPTURE and APPLY.
  - IDLE: burst_active=1 loads acc=sext(error_in), cnt=1, and moves to ACCUM.
  - ACCUM: while burst_active=1, acc = sat_ACC(acc + sext(error_in)) and cnt++. Once cnt saturates, further samples are dropped (acc and cnt hold).
  - ACCUM, burst_active=0: go to CAPTURE.
- CAPTURE:
  - If cnt < MIN_SAMPLES, discard: no update, go to IDLE.
  - Otherwise captured_err <= acc, integ <= clamp(integ + sext(acc), ±INT_LIM), and go to APPLY.
  - In both cases acc and cnt are cleared.
- APPLY:
  - offset_out <= sat_OUT((captured_err >>> KP_SHIFT) + (integ >>> KI_SHIFT)). The integ term uses the integrator value updated in CAPTURE.
  - update_valid=1 for exactly this cycle; go to IDLE.
- Latency: update_valid rises 2 cycles after the first clock edge that samples burst_active=0.
- burst_active during CAPTURE/APPLY is ignored; those samples are lost. If it is still high in IDLE, a new accumulation starts.
- All shifts are arithmetic. sat_N clamps to [-2^(N-1), 2^(N-1)-1]; the INT_LIM clamp is symmetric.
- enable=0:
  - FSM forced to IDLE; acc and cnt cleared.
  - integ, offset_out, locked and holdover hold their values.
  - Miss and lock counters hold; line_strobe is ignored.
- integ_clr=1: integ=0 and offset_out=0 next cycle. This takes priority over an APPLY/CAPTURE write in the same cycle. The FSM otherwise continues.
- Lock:
  - Evaluated on each accepted update (CAPTURE, cnt ≥ MIN_SAMPLES).
  - abs(acc) < LOCK_THRESH: good_cnt++ (saturating at LOCK_LINES), and locked=1 when good_cnt reaches LOCK_LINES.
  - Otherwise good_cnt=0 and locked=0.
- Holdover:
  - A seen flag is set by an accepted update.
  - On line_strobe: if seen=0, miss_cnt++ (saturating), else miss_cnt=0; seen is then cleared.
  - miss_cnt = MISS_LINES sets holdover=1, locked=0 and good_cnt=0.
  - The next accepted update clears holdover and miss_cnt.
  - While holdover=1, APPLY still writes offset_out (that update is what exits holdover); otherwise the integrator and output are untouched.
- Simultaneous line_strobe and accepted update in the same cycle: the update counts for the line closing at that strobe, so miss_cnt=0.

Decomposition:
- Package burst_pi_pkg holds:
  - state_t enum (IDLE, ACCUM, CAPTURE, APPLY);
  - generic signed saturate function (value, width);
  - abs helper.
- One sub-module, burst_lock_monitor, owns good_cnt, miss_cnt, seen, locked and holdover.
  - Inputs: clk, rst, enable, line_strobe, accept pulse, good flag.
- The top module keeps the FSM, accumulator and PI datapath.

Test Plan:
- Burst of 40 cycles, error_in=+100 → captured_err=4000, integ=4000, offset_out=(4000>>>6)+(4000>>>10)=62+3=65, update_valid 2 cycles after burst end.
- Burst of 10 cycles (< MIN_SAMPLES=16) → no update_valid, offset_out unchanged, counts as a miss at the next line_strobe.
- 8 consecutive 40-cycle bursts with error_in=+1 (sum 40 < 64) → locked=1 after the 8th update. A 9th burst with error_in=+10 (sum 400) → locked=0.
- Lock achieved, then 4 line_strobes with no burst → holdover=1, locked=0, offset_out constant. A following valid burst → holdover=0 and update_valid pulses.
- Constant error_in=+2047 over 127-cycle bursts for many lines → acc saturates at its max or integ clamps at INT_LIM=2^27, with no wrap. offset_out = (captured_err>>>6) + (2^27>>>10); sign stays positive.
- rst and integ_clr: rst asserted during ACCUM → all outputs 0 next cycle, and a burst_active fall afterwards produces no update. integ_clr in the same cycle as APPLY → offset_out=0.
